alsu_result_fifo: RTL and testbench
===================================

Name: alsu_result_fifo

Overview:
Downstream stage of the ALSU. Captures each registered ALSU result (6-bit signed out) plus an error tag (leds != 0) into a small FIFO so a slower consumer can drain results under a read handshake. Also keeps running statistics for the monitor/scoreboard path:
- saturating signed sum of drained good results
- saturating count of error-tagged results
- sticky overflow and underflow flags

Parameters:
DEPTH, 8, number of FIFO entries; power of 2, >= 2.
DATA_W, 6, result width; matches ALSU out.
ACC_W, 12, width of signed running-sum accumulator.

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
wr_en  in  1  ALSU result valid this cycle (no upstream backpressure)
wr_data  in  DATA_W  signed ALSU result
wr_err  in  1  ALSU invalid-op indication (leds != 0)
rd_en  in  1  consumer pop request
clr_stats  in  1  synchronous clear of statistics only
rd_valid  out  1  rd_data/rd_err valid this cycle (one-cycle pulse per pop)
rd_data  out  DATA_W  popped result (signed)
rd_err  out  1  popped error tag
full  out  1  count == DEPTH
empty  out  1  count == 0
count  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky: write dropped while full
underflow  out  1  sticky: rd_en while empty
err_count  out  8  saturating count of accepted writes with wr_err=1
acc  out  ACC_W  saturating signed sum of popped entries with err=0

Behaviour:
- Reset (rst=1 at posedge): outputs and state go to
  - count=0, empty=1, full=0, rd_valid=0, rd_data=0, rd_err=0
  - overflow=0, underflow=0, err_count=0, acc=0
  - read and write pointers = 0
  - rst has priority over every other input, including mid-drain; FIFO contents are discarded.
- Write:
  - wr_en=1 and (not full, or full with rd_en=1): store {wr_err, wr_data} at wr_ptr; wr_ptr increments modulo DEPTH.
  - wr_en=1 while full and rd_en=0: write dropped, overflow<=1, no state change otherwise.
- Read:
  - rd_en=1 and not empty: entry at rd_ptr is registered to rd_data/rd_err; rd_valid=1 in the next cycle (1-cycle read latency); rd_ptr increments modulo DEPTH.
  - rd_en=1 while empty: underflow<=1, rd_valid=0, rd_data/rd_err hold their previous values.
  - rd_valid is 0 in any cycle not following a successful pop.
- Simultaneous rd_en and wr_en:
  - Not empty, not full: both happen, count unchanged.
  - Full: both happen; the write uses the slot freed this cycle; count stays DEPTH; no overflow.
  - Empty: write accepted; read treated as empty read (underflow<=1). There is no write-through bypass.
- count, full and empty are registered and reflect the post-edge occupancy.
- err_count: +1 per accepted write with wr_err=1; saturates at 255; dropped writes are not counted.
- acc:
  - On each successful pop with err=0: acc <= sat(acc + sign_extend(data)).
  - Saturation limits are +(2^(ACC_W-1)-1) and -2^(ACC_W-1).
  - Pops with err=1 leave acc unchanged.
- clr_stats=1:
  - Clears overflow, underflow, err_count and acc.
  - FIFO contents, pointers and count are untouched.
  - Same-cycle events are lost: clear wins over any stat update in that cycle.
- Pointer wrap: DEPTH consecutive writes followed by DEPTH reads return data in write order across the wrap boundary.

Test Plan:
1. Reset, then write 5, -3, 31 (err=0) on three cycles; pop three times -> rd_data 5, -3, 31 one cycle after each rd_en; acc=33; empty=1 after the last pop.
2. Write 9 entries with DEPTH=8 and no reads -> full=1 after the 8th write, count=8, overflow=1 after the 9th; the 9th value is never read back.
3. With FIFO full, rd_en and wr_en high in the same cycle with data 7 -> count stays 8, overflow stays 0; 7 is the last value drained.
4. rd_en with FIFO empty, simultaneous with wr_en data -32 -> underflow=1, rd_valid=0 next cycle, count=1; the next pop returns -32 and acc=-32.
5. Write data 12 err=1, then data 4 err=0; pop both -> err_count=1, rd_err 1 then 0, acc=4. Then clr_stats -> acc=0, err_count=0; occupancy unaffected.
6. Push and pop -32 repeatedly 70 times with ACC_W=12 -> acc saturates at -2048 and holds. Assert rst mid-drain -> count=0, empty=1, acc=0 on the next cycle.

Source files
------------

// File: rtl/alsu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alsu_result_fifo
// Description : Result FIFO behind the ALSU. Buffers {err, data} results for
//               a slower consumer with a registered one-cycle read, and keeps
//               running statistics (saturating signed sum of good pops,
//               saturating error count, sticky overflow/underflow).
// Revision    : 1.0 - initial release
// ============================================================================
module alsu_result_fifo #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 6,
   parameter int ACC_W  = 12
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       wr_err,
   input  logic                       rd_en,
   input  logic                       clr_stats,
   output logic                       rd_valid,
   output logic [DATA_W-1:0]          rd_data,
   output logic                       rd_err,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow,
   output logic [7:0]                 err_count,
   output logic [ACC_W-1:0]           acc
);

   localparam int c_AW = $clog2(DEPTH);
   localparam int c_CW = c_AW + 1;
   localparam logic [c_CW-1:0]  c_DEPTH   = c_CW'(DEPTH);
   localparam logic [ACC_W-1:0] c_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] c_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   // Storage: each entry carries the error tag above the data bits.
   logic [DATA_W:0]     mem_q [DEPTH];

   logic [c_AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [c_AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [c_CW-1:0]     count_q, count_d;
   logic                full_q, full_d;
   logic                empty_q, empty_d;
   logic                rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic                rd_err_q, rd_err_d;
   logic                overflow_q, overflow_d;
   logic                underflow_q, underflow_d;
   logic [7:0]          err_count_q, err_count_d;
   logic [ACC_W-1:0]    acc_q, acc_d;

   logic                do_wr;
   logic                do_rd;
   logic [DATA_W:0]     head;
   logic [ACC_W:0]      sum;

   // Next-state for pointers, occupancy, read port and statistics.
   always_comb begin
      // A full FIFO can still accept a write when a pop frees a slot this cycle.
      do_rd       = rd_en && !empty_q;
      do_wr       = wr_en && (!full_q || rd_en);
      head        = mem_q[rd_ptr_q];

      wr_ptr_d    = do_wr ? wr_ptr_q + c_AW'(1) : wr_ptr_q;
      rd_ptr_d    = do_rd ? rd_ptr_q + c_AW'(1) : rd_ptr_q;
      count_d     = count_q + (do_wr ? c_CW'(1) : c_CW'(0)) - (do_rd ? c_CW'(1) : c_CW'(0));
      full_d      = (count_d == c_DEPTH);
      empty_d     = (count_d == '0);

      rd_valid_d  = do_rd;
      rd_data_d   = do_rd ? head[DATA_W-1:0] : rd_data_q;
      rd_err_d    = do_rd ? head[DATA_W]     : rd_err_q;

      overflow_d  = overflow_q  | (wr_en && full_q && !rd_en);
      underflow_d = underflow_q | (rd_en && empty_q);

      err_count_d = err_count_q;
      if (do_wr && wr_err && (err_count_q != 8'hFF)) begin
         err_count_d = err_count_q + 8'd1;
      end

      // One extra bit of headroom; the top two bits disagree only on overflow.
      sum   = {acc_q[ACC_W-1], acc_q}
            + {{(ACC_W+1-DATA_W){head[DATA_W-1]}}, head[DATA_W-1:0]};
      acc_d = acc_q;
      if (do_rd && !head[DATA_W]) begin
         if (!sum[ACC_W] && sum[ACC_W-1]) begin
            acc_d = c_ACC_MAX;
         end else if (sum[ACC_W] && !sum[ACC_W-1]) begin
            acc_d = c_ACC_MIN;
         end else begin
            acc_d = sum[ACC_W-1:0];
         end
      end

      // A clear discards any statistic update arriving in the same cycle.
      if (clr_stats) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
         err_count_d = '0;
         acc_d       = '0;
      end
   end

   // Register stage for control, read port and statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
         rd_err_q    <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         err_count_q <= '0;
         acc_q       <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
         rd_err_q    <= rd_err_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         err_count_q <= err_count_d;
         acc_q       <= acc_d;
      end
   end

   // Entry storage is not reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (!rst && do_wr) begin
         mem_q[wr_ptr_q] <= {wr_err, wr_data};
      end
   end

   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
   assign rd_err    = rd_err_q;
   assign full      = full_q;
   assign empty     = empty_q;
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
   assign err_count = err_count_q;
   assign acc       = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_alsu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_alsu_result_fifo
// Description : Directed-vector bench for alsu_result_fifo (DEPTH=8,
//               DATA_W=6, ACC_W=12) with hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alsu_result_fifo;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [5:0]  wr_data = '0;
   logic        wr_err = 1'b0;
   logic        rd_en = 1'b0;
   logic        clr_stats = 1'b0;
   logic        rd_valid;
   logic [5:0]  rd_data;
   logic        rd_err;
   logic        full;
   logic        empty;
   logic [3:0]  count;
   logic        overflow;
   logic        underflow;
   logic [7:0]  err_count;
   logic [11:0] acc;

   int n_tests = 0;
   int n_fail  = 0;

   alsu_result_fifo #(.DEPTH(8), .DATA_W(6), .ACC_W(12)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_err(wr_err),
      .rd_en(rd_en), .clr_stats(clr_stats), .rd_valid(rd_valid), .rd_data(rd_data),
      .rd_err(rd_err), .full(full), .empty(empty), .count(count),
      .overflow(overflow), .underflow(underflow), .err_count(err_count), .acc(acc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, we;
      logic [5:0]  wd;
      logic        werr, re, clr;
      logic        rv;
      logic [5:0]  rdat;
      logic        rerr;
      logic [3:0]  cnt;
      logic        full, empty, ovf, udf;
      logic [7:0]  errc;
      logic [11:0] acc;
   } vec_t;

   function automatic vec_t mk(int r, int we, int wd, int werr, int re, int clr,
                               int rv, int rdat, int rerr, int cnt, int fl, int em,
                               int ovf, int udf, int errc, int a);
      vec_t v;
      v.rst = 1'(r);   v.we = 1'(we);   v.wd = 6'(wd);    v.werr = 1'(werr);
      v.re  = 1'(re);  v.clr = 1'(clr); v.rv = 1'(rv);    v.rdat = 6'(rdat);
      v.rerr = 1'(rerr); v.cnt = 4'(cnt); v.full = 1'(fl); v.empty = 1'(em);
      v.ovf = 1'(ovf); v.udf = 1'(udf); v.errc = 8'(errc); v.acc = 12'(a);
      return v;
   endfunction

   // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
   task automatic step(input logic r, input logic we, input logic [5:0] wd,
                       input logic werr, input logic re, input logic clr);
      rst = r; wr_en = we; wr_data = wd; wr_err = werr; rd_en = re; clr_stats = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [35:0] snap();
      return {rd_valid, rd_data, rd_err, count, full, empty, overflow, underflow, err_count, acc};
   endfunction

   vec_t vecs [23];

   initial begin
      logic [5:0] exp_q [$];
      int         model_acc;

      //             rst we  wd werr re clr | rv rdat rerr cnt full empty ovf udf errc acc
      vecs[0]  = mk(1, 0,   0, 0, 0, 0,   0,   0, 0, 0, 0, 1, 0, 0, 0,   0);
      vecs[1]  = mk(0, 1,   5, 0, 0, 0,   0,   0, 0, 1, 0, 0, 0, 0, 0,   0);
      vecs[2]  = mk(0, 1,  -3, 0, 0, 0,   0,   0, 0, 2, 0, 0, 0, 0, 0,   0);
      vecs[3]  = mk(0, 1,  31, 0, 0, 0,   0,   0, 0, 3, 0, 0, 0, 0, 0,   0);
      vecs[4]  = mk(0, 0,   0, 0, 1, 0,   1,   5, 0, 2, 0, 0, 0, 0, 0,   5);
      vecs[5]  = mk(0, 0,   0, 0, 1, 0,   1,  -3, 0, 1, 0, 0, 0, 0, 0,   2);
      vecs[6]  = mk(0, 0,   0, 0, 1, 0,   1,  31, 0, 0, 0, 1, 0, 0, 0,  33);
      vecs[7]  = mk(0, 0,   0, 0, 0, 0,   0,  31, 0, 0, 0, 1, 0, 0, 0,  33);
      vecs[8]  = mk(0, 0,   0, 0, 0, 1,   0,  31, 0, 0, 0, 1, 0, 0, 0,   0);
      vecs[9]  = mk(0, 1, -32, 0, 1, 0,   0,  31, 0, 1, 0, 0, 0, 1, 0,   0);
      vecs[10] = mk(0, 0,   0, 0, 1, 0,   1, -32, 0, 0, 0, 1, 0, 1, 0, -32);
      vecs[11] = mk(0, 0,   0, 0, 0, 1,   0, -32, 0, 0, 0, 1, 0, 0, 0,   0);
      vecs[12] = mk(0, 1,  12, 1, 0, 0,   0, -32, 0, 1, 0, 0, 0, 0, 1,   0);
      vecs[13] = mk(0, 1,   4, 0, 0, 0,   0, -32, 0, 2, 0, 0, 0, 0, 1,   0);
      vecs[14] = mk(0, 0,   0, 0, 1, 0,   1,  12, 1, 1, 0, 0, 0, 0, 1,   0);
      vecs[15] = mk(0, 0,   0, 0, 1, 0,   1,   4, 0, 0, 0, 1, 0, 0, 1,   4);
      vecs[16] = mk(0, 1,   1, 0, 0, 1,   0,   4, 0, 1, 0, 0, 0, 0, 0,   0);
      vecs[17] = mk(0, 0,   0, 0, 1, 1,   1,   1, 0, 0, 0, 1, 0, 0, 0,   0);
      vecs[18] = mk(0, 1,   2, 1, 0, 1,   0,   1, 0, 1, 0, 0, 0, 0, 0,   0);
      vecs[19] = mk(0, 0,   0, 0, 1, 0,   1,   2, 1, 0, 0, 1, 0, 0, 0,   0);
      vecs[20] = mk(0, 1,  10, 0, 0, 0,   0,   2, 1, 1, 0, 0, 0, 0, 0,   0);
      vecs[21] = mk(0, 1,  11, 0, 1, 0,   1,  10, 0, 1, 0, 0, 0, 0, 0,  10);
      vecs[22] = mk(0, 0,   0, 0, 1, 0,   1,  11, 0, 0, 0, 1, 0, 0, 0,  21);

      for (int i = 0; i < 23; i++) begin
         step(vecs[i].rst, vecs[i].we, vecs[i].wd, vecs[i].werr, vecs[i].re, vecs[i].clr);
         chk($sformatf("vec%0d", i), snap(),
             {vecs[i].rv, vecs[i].rdat, vecs[i].rerr, vecs[i].cnt, vecs[i].full,
              vecs[i].empty, vecs[i].ovf, vecs[i].udf, vecs[i].errc, vecs[i].acc});
      end

      // Fill to full, overflow on the 9th write, then push+pop while full.
      step(0, 0, 6'd0, 0, 0, 1);
      chk("pre_fill_clr", {28'd0, acc, empty, count}, {28'd0, 12'd0, 1'b1, 4'd0});
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 6'(i + 1), 0, 0, 0);
         exp_q.push_back(6'(i + 1));
         chk($sformatf("fill%0d", i), {30'd0, count, full, empty},
             {30'd0, 4'(i + 1), (i == 7) ? 1'b1 : 1'b0, 1'b0});
      end
      step(0, 1, 6'd20, 0, 0, 0);
      chk("ovf_drop", {32'd0, count, overflow, full}, {32'd0, 4'd8, 1'b1, 1'b1});
      step(0, 0, 6'd0, 0, 0, 1);
      chk("clr_keeps_occ", {32'd0, count, overflow, full}, {32'd0, 4'd8, 1'b0, 1'b1});
      step(0, 1, 6'd7, 0, 1, 0);
      exp_q.push_back(6'd7);
      chk("full_rdwr", {26'd0, rd_valid, rd_data, count, overflow},
          {26'd0, 1'b1, exp_q.pop_front(), 4'd8, 1'b0});
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 6'd0, 0, 1, 0);
         chk($sformatf("drain%0d", i), {29'd0, rd_valid, rd_data}, {29'd0, 1'b1, exp_q.pop_front()});
      end
      chk("drain_end", {30'd0, acc, empty, count, overflow},
          {30'd0, 12'd43, 1'b1, 4'd0, 1'b0});
      step(0, 0, 6'd0, 0, 0, 0);
      chk("idle_no_valid", {35'd0, rd_valid}, {35'd0, 1'b0});

      // Negative saturation of the accumulator.
      step(0, 0, 6'd0, 0, 0, 1);
      model_acc = 0;
      for (int i = 0; i < 70; i++) begin
         step(0, 1, 6'h20, 0, 0, 0);
         step(0, 0, 6'd0, 0, 1, 0);
         model_acc = model_acc - 32;
         if (model_acc < -2048) model_acc = -2048;
         chk($sformatf("sat%0d", i), {17'd0, rd_valid, rd_data, acc},
             {17'd0, 1'b1, 6'h20, 12'(model_acc)});
      end
      chk("sat_final", {24'd0, acc}, {24'd0, 12'h800});

      // Reset mid-drain discards contents and statistics.
      step(0, 1, 6'd3, 0, 0, 0);
      step(0, 1, 6'd4, 0, 0, 0);
      step(0, 1, 6'd5, 0, 0, 0);
      step(0, 0, 6'd0, 0, 1, 0);
      chk("pre_rst_pop", {25'd0, rd_data, count, acc[0]}, {25'd0, 6'd3, 4'd2, 1'b1});
      step(1, 0, 6'd0, 0, 1, 0);
      chk("rst_mid_drain", snap(), {1'b0, 6'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 12'd0});
      step(0, 0, 6'd0, 0, 1, 0);
      chk("post_rst_empty_rd", {33'd0, rd_valid, underflow, empty}, {33'd0, 1'b0, 1'b1, 1'b1});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
